eu_seq: RTL and testbench

EU_SEQ -- requirements
Module: eu_seq

---
 rtl/eu_seq.sv | 234 +++++++++++++++++++++++
 tb/tb_eu_seq.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eu_seq.sv
// -----------------------------------------------------------------------------
// eu_seq -- execution-unit sequencer
//
// Accepts one instruction at a time from the decoder with a valid/ready
// handshake. It then walks a small FSM (IDLE, EXEC, MEM_RD, MEM_WB, MEM_WR)
// that drives the datapath and data-memory control strobes for that
// instruction.
//
// Ports
//   clk                 clock, rising edge
//   rst                 asynchronous reset, active low
//   instr_valid_i       decoder offers an instruction
//   instr_ready_o       sequencer can accept (high only in IDLE)
//   instr_op_i [3:0]    opcode
//   instr_dst_i         destination register (0=R0, 1=R1)
//   instr_imm_i [7:0]   immediate / data-memory address
//   imm_o [7:0]         immediate latched at accept
//   err_o               sticky illegal-opcode flag
//   data_mem_rd_enb_o   data memory read enable
//   data_mem_wr_enb_o   data memory write enable
//   wr_data_sel_o       store data source (0=R0, 1=R1)
//   r0_const_sel_o      ALU operand 0 takes imm_o
//   r1_const_sel_o      ALU operand 1 takes imm_o
//   cf_sel_o            ALU carry-in forced to 1
//   cmp_flag_sel_o      compare flag loads ALU carry-out
//   alu_sel_0_o [1:0]   ALU function (ADD/AND/OR/XOR)
//   alu_sel_1_o         select shifter output
//   inv_sel_o           invert ALU operand 1
//   shftr_sel_o         shift right by one
//   shftl_sel_o         shift left by one
//   r0_sel_o [1:0]      R0 next value (00 mem, 01 imm, 10 ALU, 11 hold)
//   r1_sel_o [1:0]      R1 next value, same encoding
//
// Configuration
//   EU_SEQ_SHIFT_EN     when defined, opcodes A (SHR) and B (SHL) are
//                       executed; otherwise they are illegal and the shifter
//                       controls are tied low.
// -----------------------------------------------------------------------------
module eu_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid_i,
    output logic       instr_ready_o,
    input  logic [3:0] instr_op_i,
    input  logic       instr_dst_i,
    input  logic [7:0] instr_imm_i,
    output logic [7:0] imm_o,
    output logic       err_o,
    output logic       data_mem_rd_enb_o,
    output logic       data_mem_wr_enb_o,
    output logic       wr_data_sel_o,
    output logic       r0_const_sel_o,
    output logic       r1_const_sel_o,
    output logic       cf_sel_o,
    output logic       cmp_flag_sel_o,
    output logic [1:0] alu_sel_0_o,
    output logic       alu_sel_1_o,
    output logic       inv_sel_o,
    output logic       shftr_sel_o,
    output logic       shftl_sel_o,
    output logic [1:0] r0_sel_o,
    output logic [1:0] r1_sel_o
);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_LD  = 4'h2;
    localparam logic [3:0] OP_ST  = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8;
    localparam logic [3:0] OP_CMP = 4'h9;
    localparam logic [3:0] OP_SHR = 4'hA;
    localparam logic [3:0] OP_SHL = 4'hB;

    localparam logic [1:0] RSEL_MEM  = 2'b00;
    localparam logic [1:0] RSEL_IMM  = 2'b01;
    localparam logic [1:0] RSEL_ALU  = 2'b10;
    localparam logic [1:0] RSEL_HOLD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] op_q;
    logic       dst_q;
    logic       accept;

    // Opcodes beyond the implemented set raise err_o.
    function automatic logic op_legal(input logic [3:0] op);
`ifdef EU_SEQ_SHIFT_EN
        return (op <= OP_SHL);
`else
        return (op <= OP_CMP);
`endif
    endfunction

    assign instr_ready_o = (state == S_IDLE);
    assign accept        = instr_valid_i && instr_ready_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            op_q  <= OP_NOP;
            dst_q <= 1'b0;
            imm_o <= 8'h00;
            err_o <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q  <= instr_op_i;
                dst_q <= instr_dst_i;
                imm_o <= instr_imm_i;
                if (!op_legal(instr_op_i)) begin
                    err_o <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (instr_op_i == OP_LD) begin
                        state_nxt = S_MEM_RD;
                    end else if (instr_op_i == OP_ST) begin
                        state_nxt = S_MEM_WR;
                    end else begin
                        state_nxt = S_EXEC;
                    end
                end
            end
            S_EXEC:   state_nxt = S_IDLE;
            S_MEM_RD: state_nxt = S_MEM_WB;   // read data arrives one cycle later
            S_MEM_WB: state_nxt = S_IDLE;
            S_MEM_WR: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Control decode works only from registered state/op/dst. The
    // destination-relative selects (rd_sel, rd_const) are steered onto
    // R0 or R1 at the end.
    logic [1:0] rd_sel;
    logic       rd_const;

    always_comb begin
        rd_sel            = RSEL_HOLD;
        rd_const          = 1'b0;
        data_mem_rd_enb_o = 1'b0;
        data_mem_wr_enb_o = 1'b0;
        wr_data_sel_o     = 1'b0;
        cf_sel_o          = 1'b0;
        cmp_flag_sel_o    = 1'b0;
        alu_sel_0_o       = 2'b00;
        alu_sel_1_o       = 1'b0;
        inv_sel_o         = 1'b0;
        shftr_sel_o       = 1'b0;
        shftl_sel_o       = 1'b0;

        case (state)
            S_EXEC: begin
                case (op_q)
                    OP_NOP: ;
                    OP_LDI: begin
                        rd_sel   = RSEL_IMM;
                        rd_const = 1'b1;
                    end
                    OP_ADD: rd_sel = RSEL_ALU;
                    OP_SUB: begin
                        inv_sel_o = 1'b1;
                        cf_sel_o  = 1'b1;
                        rd_sel    = RSEL_ALU;
                    end
                    OP_AND: begin
                        alu_sel_0_o = 2'b01;
                        rd_sel      = RSEL_ALU;
                    end
                    OP_OR: begin
                        alu_sel_0_o = 2'b10;
                        rd_sel      = RSEL_ALU;
                    end
                    OP_XOR: begin
                        alu_sel_0_o = 2'b11;
                        rd_sel      = RSEL_ALU;
                    end
                    OP_CMP: begin
                        // Subtract only for the carry-out; no register write.
                        inv_sel_o      = 1'b1;
                        cf_sel_o       = 1'b1;
                        cmp_flag_sel_o = 1'b1;
                    end
                    OP_SHR: begin
`ifdef EU_SEQ_SHIFT_EN
                        alu_sel_1_o = 1'b1;
                        shftr_sel_o = 1'b1;
                        rd_sel      = RSEL_ALU;
`endif
                    end
                    OP_SHL: begin
`ifdef EU_SEQ_SHIFT_EN
                        alu_sel_1_o = 1'b1;
                        shftl_sel_o = 1'b1;
                        rd_sel      = RSEL_ALU;
`endif
                    end
                    default: ;   // illegal opcode: controls stay at default
                endcase
            end
            S_MEM_RD: data_mem_rd_enb_o = 1'b1;
            S_MEM_WB: rd_sel = RSEL_MEM;
            S_MEM_WR: begin
                data_mem_wr_enb_o = 1'b1;
                wr_data_sel_o     = dst_q;
            end
            default: ;
        endcase
    end

    assign r0_sel_o       = dst_q ? RSEL_HOLD : rd_sel;
    assign r1_sel_o       = dst_q ? rd_sel    : RSEL_HOLD;
    assign r0_const_sel_o = !dst_q && rd_const;
    assign r1_const_sel_o = dst_q  && rd_const;

endmodule

// File: tb/tb_eu_seq.sv
// -----------------------------------------------------------------------------
// tb_eu_seq -- self-checking bench for eu_seq.
// A transaction-level model predicts every output on every cycle. Directed
// literal checks pin key scenarios.
// -----------------------------------------------------------------------------
module tb_eu_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       instr_valid_i = 1'b0;
    logic       instr_ready_o;
    logic [3:0] instr_op_i = 4'h0;
    logic       instr_dst_i = 1'b0;
    logic [7:0] instr_imm_i = 8'h00;
    logic [7:0] imm_o;
    logic       err_o;
    logic       data_mem_rd_enb_o, data_mem_wr_enb_o, wr_data_sel_o;
    logic       r0_const_sel_o, r1_const_sel_o, cf_sel_o, cmp_flag_sel_o;
    logic [1:0] alu_sel_0_o;
    logic       alu_sel_1_o, inv_sel_o, shftr_sel_o, shftl_sel_o;
    logic [1:0] r0_sel_o, r1_sel_o;

    eu_seq dut (
        .clk               (clk),
        .rst               (rst),
        .instr_valid_i     (instr_valid_i),
        .instr_ready_o     (instr_ready_o),
        .instr_op_i        (instr_op_i),
        .instr_dst_i       (instr_dst_i),
        .instr_imm_i       (instr_imm_i),
        .imm_o             (imm_o),
        .err_o             (err_o),
        .data_mem_rd_enb_o (data_mem_rd_enb_o),
        .data_mem_wr_enb_o (data_mem_wr_enb_o),
        .wr_data_sel_o     (wr_data_sel_o),
        .r0_const_sel_o    (r0_const_sel_o),
        .r1_const_sel_o    (r1_const_sel_o),
        .cf_sel_o          (cf_sel_o),
        .cmp_flag_sel_o    (cmp_flag_sel_o),
        .alu_sel_0_o       (alu_sel_0_o),
        .alu_sel_1_o       (alu_sel_1_o),
        .inv_sel_o         (inv_sel_o),
        .shftr_sel_o       (shftr_sel_o),
        .shftl_sel_o       (shftl_sel_o),
        .r0_sel_o          (r0_sel_o),
        .r1_sel_o          (r1_sel_o)
    );

    always #5 clk = ~clk;

`ifdef EU_SEQ_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    typedef struct packed {
        logic       ready;
        logic [7:0] imm;
        logic       err;
        logic       rd, wr, wds, r0c, r1c, cf, cmp;
        logic [1:0] alu0;
        logic       alu1, inv, shr, shl;
        logic [1:0] r0s, r1s;
    } obs_t;

    obs_t act;
    assign act = {instr_ready_o, imm_o, err_o, data_mem_rd_enb_o, data_mem_wr_enb_o,
                  wr_data_sel_o, r0_const_sel_o, r1_const_sel_o, cf_sel_o, cmp_flag_sel_o,
                  alu_sel_0_o, alu_sel_1_o, inv_sel_o, shftr_sel_o, shftl_sel_o,
                  r0_sel_o, r1_sel_o};

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int last_acc = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] r);
        tests++;
        if (a !== r) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, a, r);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural model ----------------
    // An instruction occupies the sequencer for a number of cycles after
    // accept (2 for LD, 1 otherwise); each of those cycles has a fixed
    // control pattern. Ready is high whenever nothing is in flight.
    logic       m_busy = 1'b0;
    logic [3:0] m_op   = 4'h0;
    logic       m_dst  = 1'b0;
    logic [7:0] m_imm  = 8'h00;
    logic       m_err  = 1'b0;
    int         m_ph   = 0;

    function automatic bit legal(input logic [3:0] op);
        return (op <= 4'h9) || (SHIFT_EN && op <= 4'hB);
    endfunction

    function automatic int nphase(input logic [3:0] op);
        return (op == 4'h2) ? 2 : 1;
    endfunction

    function automatic obs_t ctrl(input logic busy, input logic [3:0] op,
                                  input logic d, input int ph);
        obs_t o;
        logic [1:0] rs;
        logic rc;
        o  = '0;
        rs = 2'b11;
        rc = 1'b0;
        if (busy) begin
            case (op)
                4'h1: begin rs = 2'b01; rc = 1'b1; end
                4'h2: if (ph == 0) o.rd = 1'b1; else rs = 2'b00;
                4'h3: begin o.wr = 1'b1; o.wds = d; end
                4'h4: rs = 2'b10;
                4'h5: begin o.inv = 1'b1; o.cf = 1'b1; rs = 2'b10; end
                4'h6: begin o.alu0 = 2'd1; rs = 2'b10; end
                4'h7: begin o.alu0 = 2'd2; rs = 2'b10; end
                4'h8: begin o.alu0 = 2'd3; rs = 2'b10; end
                4'h9: begin o.inv = 1'b1; o.cf = 1'b1; o.cmp = 1'b1; end
                4'hA: if (SHIFT_EN) begin o.alu1 = 1'b1; o.shr = 1'b1; rs = 2'b10; end
                4'hB: if (SHIFT_EN) begin o.alu1 = 1'b1; o.shl = 1'b1; rs = 2'b10; end
                default: ;
            endcase
        end
        o.r0s = d ? 2'b11 : rs;
        o.r1s = d ? rs : 2'b11;
        o.r0c = !d && rc;
        o.r1c = d && rc;
        return o;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 1'b0;
            m_imm  <= 8'h00;
            m_err  <= 1'b0;
            m_ph   <= 0;
        end else if (!m_busy) begin
            if (instr_valid_i) begin
                m_busy <= 1'b1;
                m_op   <= instr_op_i;
                m_dst  <= instr_dst_i;
                m_imm  <= instr_imm_i;
                m_ph   <= 0;
                if (!legal(instr_op_i)) m_err <= 1'b1;
            end
        end else begin
            if (m_ph + 1 >= nphase(m_op)) m_busy <= 1'b0;
            m_ph <= m_ph + 1;
        end
    end

    function automatic obs_t model_obs();
        obs_t e;
        e = ctrl(m_busy, m_op, m_dst, m_ph);
        e.ready = !m_busy;
        e.imm   = m_imm;
        e.err   = m_err;
        return e;
    endfunction

    always @(negedge clk) chk("outputs", 32'(act), 32'(model_obs()));

    // ---------------- stimulus ----------------
    task automatic send(input logic [3:0] op, input logic d, input logic [7:0] imm);
        int n;
        @(negedge clk);
        instr_valid_i = 1'b1;
        instr_op_i    = op;
        instr_dst_i   = d;
        instr_imm_i   = imm;
        n = 0;
        while (!instr_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("ready_wait", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        last_acc = cyc;
    endtask

    task automatic drop();
        @(negedge clk);
        instr_valid_i = 1'b0;
    endtask

    initial begin
        int a_st;
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a_st;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(instr_ready_o), 32'd1);
        chk("rst_imm",   32'(imm_o), 32'h00);
        chk("rst_err",   32'(err_o), 32'd0);
        chk("rst_rsel",  32'({r0_sel_o, r1_sel_o}), 32'hF);
        @(negedge clk);
        rst = 1'b1;

        // LDI R0, 0x3C
        send(4'h1, 1'b0, 8'h3C);
        chk("ldi_r0sel", 32'(r0_sel_o), 32'h1);
        chk("ldi_r1sel", 32'(r1_sel_o), 32'h3);
        chk("ldi_imm",   32'(imm_o), 32'h3C);
        chk("ldi_busy",  32'(instr_ready_o), 32'd0);
        @(posedge clk); #1;
        chk("ldi_lat",   32'(instr_ready_o), 32'd1);
        drop();

        // LD R1, [0x10]
        send(4'h2, 1'b1, 8'h10);
        chk("ld_rd",   32'(data_mem_rd_enb_o), 32'd1);
        chk("ld_addr", 32'(imm_o), 32'h10);
        chk("ld_wr0",  32'(data_mem_wr_enb_o), 32'd0);
        @(posedge clk); #1;
        chk("ld_wb",   32'(r1_sel_o), 32'h0);
        chk("ld_rdoff", 32'(data_mem_rd_enb_o), 32'd0);
        chk("ld_wr1",  32'(data_mem_wr_enb_o), 32'd0);
        chk("ld_busy", 32'(instr_ready_o), 32'd0);
        @(posedge clk); #1;
        chk("ld_lat",  32'(instr_ready_o), 32'd1);
        drop();

        // SUB R0
        send(4'h5, 1'b0, 8'h00);
        chk("sub_ctl", 32'({alu_sel_0_o, inv_sel_o, cf_sel_o, r0_sel_o, r1_sel_o}), 32'b00_1_1_10_11);
        drop();

        // CMP R0
        send(4'h9, 1'b0, 8'h00);
        chk("cmp_ctl", 32'({alu_sel_0_o, inv_sel_o, cf_sel_o, cmp_flag_sel_o, r0_sel_o, r1_sel_o}),
            32'b00_1_1_1_11_11);

        // ST R1 -> [0xFF], valid held; next instruction follows 2 cycles later
        send(4'h3, 1'b1, 8'hFF);
        a_st = last_acc;
        chk("st_wr",  32'({data_mem_wr_enb_o, wr_data_sel_o}), 32'b11);
        @(posedge clk); #1;
        chk("st_wr_once", 32'(data_mem_wr_enb_o), 32'd0);
        send(4'h4, 1'b0, 8'h00);
        chk("st_next_acc", 32'(last_acc - a_st), 32'd2);
        drop();

        // illegal opcode, then legal instruction: err sticks
        send(4'hE, 1'b0, 8'h00);
        chk("ill_err", 32'(err_o), 32'd1);
        drop();
        send(4'h4, 1'b1, 8'h00);
        chk("err_sticky", 32'(err_o), 32'd1);
        chk("add_r1", 32'(r1_sel_o), 32'h2);
        drop();

        // SHL R0
        send(4'hB, 1'b0, 8'h00);
`ifdef EU_SEQ_SHIFT_EN
        chk("shl_ctl", 32'({alu_sel_1_o, shftl_sel_o, shftr_sel_o, r0_sel_o}), 32'b1_1_0_10);
`else
        chk("shl_ctl", 32'({err_o, alu_sel_1_o, shftl_sel_o, r0_sel_o, r1_sel_o}), 32'b1_0_0_11_11);
`endif
        drop();

        // every opcode, both destinations, with gaps
        for (int op = 0; op < 16; op++) begin
            for (int d = 0; d < 2; d++) begin
                send(4'(op), 1'(d), 8'($urandom_range(0, 255)));
                drop();
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        // back-to-back with valid held
        for (int k = 0; k < 16; k++) begin
            send(4'(k), 1'(k % 2), 8'(k * 17));
        end
        drop();

        // reset during MEM_RD
        send(4'h2, 1'b0, 8'h77);
        chk("rstld_rd", 32'(data_mem_rd_enb_o), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rstld_rdoff", 32'(data_mem_rd_enb_o), 32'd0);
        chk("rstld_ready", 32'(instr_ready_o), 32'd1);
        chk("rstld_imm",   32'(imm_o), 32'h00);
        chk("rstld_err",   32'(err_o), 32'd0);
        drop();
        repeat (2) @(negedge clk);
        chk("rst_hold_rd", 32'({data_mem_rd_enb_o, r0_sel_o, r1_sel_o}), 32'b0_11_11);
        @(negedge clk);
        instr_valid_i = 1'b1;
        instr_op_i    = 4'h1;
        instr_dst_i   = 1'b1;
        instr_imm_i   = 8'h5A;
        rst           = 1'b1;
        @(posedge clk); #1;
        chk("first_acc_imm", 32'(imm_o), 32'h5A);
        chk("first_acc_r1",  32'(r1_sel_o), 32'h1);
        drop();

        // legal-only burst after reset keeps err clear
        for (int k = 1; k < 10; k++) begin
            send(4'(k), 1'(k % 2), 8'(k));
        end
        drop();
        repeat (3) @(negedge clk);
        chk("err_clear", 32'(err_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
